// File: rtl/axis_upsizer.sv
// -----------------------------------------------------------------------------
// axis_upsizer
//   Packs RATIO narrow AXI-Stream beats, little-endian, into one wide word.
//   A beat carrying tlast closes the word early; tkeep then marks only the
//   lanes that were filled, and unfilled lanes carry zero data and zero keep.
//   tid/tdest come from lane 0 of each word, tuser from the completing beat.
//
// Ports
//   clk                  clock, single domain
//   rst                  asynchronous reset, active low
//   s_tvalid/s_tready    narrow sink handshake (s_tready = !m_tvalid || m_tready)
//   s_tdata/s_tkeep      narrow payload, IN_DATA_WIDTH bits / IN_DATA_WIDTH/8 keep
//   s_tlast/tid/tdest/tuser  narrow sideband
//   m_tvalid/m_tready    wide source handshake
//   m_tdata/m_tkeep      wide payload, IN_DATA_WIDTH*RATIO bits
//   m_tlast/tid/tdest/tuser  wide sideband, all registered
// -----------------------------------------------------------------------------
module axis_upsizer #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int RATIO         = 4,
    parameter int ID_WIDTH      = 8,
    parameter int DEST_WIDTH    = 8,
    parameter int USER_WIDTH    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_tvalid,
    output logic                                 s_tready,
    input  logic [IN_DATA_WIDTH-1:0]             s_tdata,
    input  logic [IN_DATA_WIDTH/8-1:0]           s_tkeep,
    input  logic                                 s_tlast,
    input  logic [ID_WIDTH-1:0]                  s_tid,
    input  logic [DEST_WIDTH-1:0]                s_tdest,
    input  logic [USER_WIDTH-1:0]                s_tuser,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic [IN_DATA_WIDTH*RATIO-1:0]       m_tdata,
    output logic [IN_DATA_WIDTH/8*RATIO-1:0]     m_tkeep,
    output logic                                 m_tlast,
    output logic [ID_WIDTH-1:0]                  m_tid,
    output logic [DEST_WIDTH-1:0]                m_tdest,
    output logic [USER_WIDTH-1:0]                m_tuser
);

    localparam int OUT_W      = IN_DATA_WIDTH * RATIO;
    localparam int KEEP_IN_W  = IN_DATA_WIDTH / 8;
    localparam int KEEP_OUT_W = KEEP_IN_W * RATIO;
    localparam int LANE_W     = $clog2(RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    // Output holding register occupancy.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    out_state_t                 out_state_r;
    out_state_t                 out_state_s;

    logic [LANE_W-1:0]          lane_r;
    logic [OUT_W-1:0]           acc_data_r;
    logic [KEEP_OUT_W-1:0]      acc_keep_r;
    logic [ID_WIDTH-1:0]        acc_tid_r;
    logic [DEST_WIDTH-1:0]      acc_tdest_r;

    logic [OUT_W-1:0]           m_tdata_r;
    logic [KEEP_OUT_W-1:0]      m_tkeep_r;
    logic                       m_tlast_r;
    logic [ID_WIDTH-1:0]        m_tid_r;
    logic [DEST_WIDTH-1:0]      m_tdest_r;
    logic [USER_WIDTH-1:0]      m_tuser_r;

    logic                       s_ready_s;
    logic                       accept_s;
    logic                       complete_s;
    logic [OUT_W-1:0]           word_data_s;
    logic [KEEP_OUT_W-1:0]      word_keep_s;
    logic [ID_WIDTH-1:0]        word_tid_s;
    logic [DEST_WIDTH-1:0]      word_tdest_s;

    // Ready is forced low while reset is asserted so nothing is accepted then.
    assign s_ready_s  = rst && ((out_state_r == OUT_EMPTY) || m_tready);
    assign accept_s   = s_tvalid && s_ready_s;
    assign complete_s = accept_s && ((lane_r == LAST_LANE) || s_tlast);

    assign s_tready = s_ready_s;
    assign m_tvalid = (out_state_r == OUT_FULL);
    assign m_tdata  = m_tdata_r;
    assign m_tkeep  = m_tkeep_r;
    assign m_tlast  = m_tlast_r;
    assign m_tid    = m_tid_r;
    assign m_tdest  = m_tdest_r;
    assign m_tuser  = m_tuser_r;

    // Merge the incoming beat into the current lane and choose the next holding state.
    always_comb begin
        word_data_s  = acc_data_r;
        word_keep_s  = acc_keep_r;
        word_tid_s   = acc_tid_r;
        word_tdest_s = acc_tdest_r;
        out_state_s  = out_state_r;

        word_data_s[lane_r*IN_DATA_WIDTH +: IN_DATA_WIDTH] = s_tdata;
        word_keep_s[lane_r*KEEP_IN_W +: KEEP_IN_W]         = s_tkeep;

        // Sideband of a word belongs to its first beat.
        if (lane_r == {LANE_W{1'b0}}) begin
            word_tid_s   = s_tid;
            word_tdest_s = s_tdest;
        end else begin
            word_tid_s   = acc_tid_r;
            word_tdest_s = acc_tdest_r;
        end

        case (out_state_r)
            OUT_EMPTY: begin
                if (complete_s) begin
                    out_state_s = OUT_FULL;
                end else begin
                    out_state_s = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                // A completion on the draining edge reloads without a bubble.
                if (complete_s) begin
                    out_state_s = OUT_FULL;
                end else if (m_tready) begin
                    out_state_s = OUT_EMPTY;
                end else begin
                    out_state_s = OUT_FULL;
                end
            end
            default: begin
                out_state_s = OUT_EMPTY;
            end
        endcase
    end

    // Lane counter and partial-word accumulator; cleared whenever a word completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_r      <= {LANE_W{1'b0}};
            acc_data_r  <= {OUT_W{1'b0}};
            acc_keep_r  <= {KEEP_OUT_W{1'b0}};
            acc_tid_r   <= {ID_WIDTH{1'b0}};
            acc_tdest_r <= {DEST_WIDTH{1'b0}};
        end else if (accept_s) begin
            if (complete_s) begin
                lane_r      <= {LANE_W{1'b0}};
                acc_data_r  <= {OUT_W{1'b0}};
                acc_keep_r  <= {KEEP_OUT_W{1'b0}};
                acc_tid_r   <= {ID_WIDTH{1'b0}};
                acc_tdest_r <= {DEST_WIDTH{1'b0}};
            end else begin
                lane_r      <= lane_r + LANE_W'(1);
                acc_data_r  <= word_data_s;
                acc_keep_r  <= word_keep_s;
                acc_tid_r   <= word_tid_s;
                acc_tdest_r <= word_tdest_s;
            end
        end else begin
            lane_r      <= lane_r;
            acc_data_r  <= acc_data_r;
            acc_keep_r  <= acc_keep_r;
            acc_tid_r   <= acc_tid_r;
            acc_tdest_r <= acc_tdest_r;
        end
    end

    // Output holding register; payload only changes when a new word completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_state_r <= OUT_EMPTY;
            m_tdata_r   <= {OUT_W{1'b0}};
            m_tkeep_r   <= {KEEP_OUT_W{1'b0}};
            m_tlast_r   <= 1'b0;
            m_tid_r     <= {ID_WIDTH{1'b0}};
            m_tdest_r   <= {DEST_WIDTH{1'b0}};
            m_tuser_r   <= {USER_WIDTH{1'b0}};
        end else begin
            out_state_r <= out_state_s;
            if (complete_s) begin
                m_tdata_r <= word_data_s;
                m_tkeep_r <= word_keep_s;
                m_tlast_r <= s_tlast;
                m_tid_r   <= word_tid_s;
                m_tdest_r <= word_tdest_s;
                m_tuser_r <= s_tuser;
            end else begin
                m_tdata_r <= m_tdata_r;
                m_tkeep_r <= m_tkeep_r;
                m_tlast_r <= m_tlast_r;
                m_tid_r   <= m_tid_r;
                m_tdest_r <= m_tdest_r;
                m_tuser_r <= m_tuser_r;
            end
        end
    end

endmodule
